// File: rtl/boruss_imem_responder.sv
// ---------------------------------------------------------------------------
// boruss_imem_responder
//
// Instruction-memory responder for the CPU fetch path, with a built-in
// byte-stream program loader. The CPU is kept idle (cpu_run low) while a
// program is cleared/loaded. Fetches return registered data one cycle after
// the address, and only while the block is in RUN; otherwise the fetch data
// is FILL_BYTE (the HALT opcode).
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-high reset
//   instruction_addr  fetch address from the CPU
//   instruction_data  registered instruction byte
//   load_valid        loader byte valid
//   load_data         loader byte
//   load_last         final program byte (qualified by load_valid)
//   load_ready        a byte is accepted this cycle when load_valid is high
//   load_restart      single-cycle pulse: leave RUN and re-arm the loader
//   cpu_run           high only in RUN (drives the CPU's active-low reset)
//   load_count        number of bytes accepted in the current load
//   load_error        sticky error flag (overflow / checksum mismatch)
//
// Optional feature (macro BORUSS_IMEM_CHECKSUM_EN):
//   After the last program byte a CHECK state expects one extra byte equal to
//   the XOR of all program bytes. Match enters RUN; mismatch flags load_error
//   and returns to IDLE. The checksum byte is neither stored nor counted.
// ---------------------------------------------------------------------------
module boruss_imem_responder #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] instruction_addr,
    output logic [7:0]        instruction_data,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              load_restart,
    output logic              cpu_run,
    output logic [ADDR_W:0]   load_count,
    output logic              load_error
);

    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_STEP = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] CLR_STEP = ADDR_W'(1);

`ifdef BORUSS_IMEM_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CHECK
    } state_t;
`else
    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              error_q, error_d;
    logic [7:0]        idata_q, idata_d;
`ifdef BORUSS_IMEM_CHECKSUM_EN
    logic [7:0]        xsum_q, xsum_d;
`endif

    logic [7:0]        mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              handshake;

    // Ready depends only on registered state, so reset drops it immediately.
`ifdef BORUSS_IMEM_CHECKSUM_EN
    assign load_ready = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                        (state_q == S_CHECK);
`else
    assign load_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
`endif
    assign handshake        = load_valid && load_ready;
    assign cpu_run          = (state_q == S_RUN);
    assign load_count       = count_q;
    assign load_error       = error_q;
    assign instruction_data = idata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            count_q   <= '0;
            error_q   <= 1'b0;
            idata_q   <= FILL_BYTE;
`ifdef BORUSS_IMEM_CHECKSUM_EN
            xsum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            count_q   <= count_d;
            error_q   <= error_d;
            idata_q   <= idata_d;
`ifdef BORUSS_IMEM_CHECKSUM_EN
            xsum_q    <= xsum_d;
`endif
        end
    end

    // Memory contents are deliberately not reset; CLEAR rewrites them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        count_d   = count_q;
        error_d   = error_q;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = FILL_BYTE;
`ifdef BORUSS_IMEM_CHECKSUM_EN
        xsum_d    = xsum_q;
`endif
        // Reads are gated on the registered state, so a fetch can never
        // observe a location being written (writes only happen outside RUN).
        idata_d   = (state_q == S_RUN) ? mem[instruction_addr] : FILL_BYTE;

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + CLR_STEP;
                if (clr_cnt_q == '1) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                count_d = '0;
`ifdef BORUSS_IMEM_CHECKSUM_EN
                xsum_d  = '0;
`endif
                if (handshake) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    mem_wdata = load_data;
                    count_d   = CNT_STEP;
`ifdef BORUSS_IMEM_CHECKSUM_EN
                    xsum_d    = load_data;
                    // A checksum failure stays visible until the next load starts.
                    error_d   = 1'b0;
                    state_d   = load_last ? S_CHECK : S_LOAD;
`else
                    state_d   = load_last ? S_RUN : S_LOAD;
`endif
                end
            end

            S_LOAD: begin
                if (handshake) begin
                    if (count_q == CNT_FULL) begin
                        error_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = count_q[ADDR_W-1:0];
                        mem_wdata = load_data;
                        count_d   = count_q + CNT_STEP;
`ifdef BORUSS_IMEM_CHECKSUM_EN
                        xsum_d    = xsum_q ^ load_data;
`endif
                    end
                    // error_d includes an overflow raised by this same byte.
                    if (load_last) begin
`ifdef BORUSS_IMEM_CHECKSUM_EN
                        state_d = error_d ? S_IDLE : S_CHECK;
`else
                        state_d = error_d ? S_IDLE : S_RUN;
`endif
                    end
                end
            end

`ifdef BORUSS_IMEM_CHECKSUM_EN
            S_CHECK: begin
                if (handshake) begin
                    if (load_data == xsum_q) begin
                        state_d = S_RUN;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif

            S_RUN: begin
                if (load_restart) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_CLEAR;
            end
        endcase

        // Entering IDLE always presents an empty load.
        if (state_d == S_IDLE) begin
            count_d = '0;
`ifndef BORUSS_IMEM_CHECKSUM_EN
            error_d = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_boruss_imem_responder.sv
module tb_boruss_imem_responder;

    logic       clk;
    logic       reset;
    logic [7:0] instruction_addr;
    logic [7:0] instruction_data;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       load_restart;
    logic       cpu_run;
    logic [8:0] load_count;
    logic       load_error;

    int n_tests = 0;
    int n_fail  = 0;

    boruss_imem_responder #(
        .ADDR_W   (8),
        .FILL_BYTE(8'hFF)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instruction_addr(instruction_addr),
        .instruction_data(instruction_data),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .load_last       (load_last),
        .load_ready      (load_ready),
        .load_restart    (load_restart),
        .cpu_run         (cpu_run),
        .load_count      (load_count),
        .load_error      (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       restart;
        logic [7:0] addr;
        logic       exp_ready;
        logic       exp_run;
        logic [8:0] exp_count;
        logic       exp_error;
        logic       chk_idata;
        logic [7:0] exp_idata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                                input logic r, input logic [7:0] a,
                                input logic rdy, input logic run, input logic [8:0] cnt,
                                input logic err, input logic ci, input logic [7:0] id);
        vec_t t;
        t.valid = v; t.data = d; t.last = l; t.restart = r; t.addr = a;
        t.exp_ready = rdy; t.exp_run = run; t.exp_count = cnt;
        t.exp_error = err; t.chk_idata = ci; t.exp_idata = id;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic r, input logic [7:0] a);
        load_valid       = v;
        load_data        = d;
        load_last        = l;
        load_restart     = r;
        instruction_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drive();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    // Pulse restart from RUN; afterwards the block is in IDLE.
    task automatic restart_pulse(input string tag);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        tick();
        idle_drive();
        check({tag, " restart run"}, 32'(cpu_run), 32'd0);
    endtask

    // Send a one-byte program (plus its checksum when enabled) to reach RUN.
    task automatic load_one(input logic [7:0] b);
        drive(1'b1, b, 1'b1, 1'b0, 8'h00);
        tick();
`ifdef BORUSS_IMEM_CHECKSUM_EN
        drive(1'b1, b, 1'b0, 1'b0, 8'h00);
        tick();
`endif
        idle_drive();
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        drive(1'b0, 8'h00, 1'b0, 1'b0, a);
        tick();
        check(name, 32'(instruction_data), 32'(exp));
    endtask

    task automatic clear_phase(input string tag);
        repeat (255) tick();
        check({tag, " clear ready"}, 32'(load_ready), 32'd0);
        tick();
        check({tag, " idle ready"}, 32'(load_ready), 32'd1);
        check({tag, " idle data"}, 32'(instruction_data), 32'hFF);
        check({tag, " idle run"}, 32'(cpu_run), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        idle_drive();

        // ---------------- table: main load / fetch / restart ----------------
        vecs.push_back(mk(1, 8'h11, 0, 0, 8'd0, 1, 0, 9'd1, 0, 1, 8'hFF));
        vecs.push_back(mk(1, 8'h22, 0, 0, 8'd0, 1, 0, 9'd2, 0, 1, 8'hFF));
`ifdef BORUSS_IMEM_CHECKSUM_EN
        vecs.push_back(mk(1, 8'h33, 1, 0, 8'd0, 1, 0, 9'd3, 0, 1, 8'hFF));
        vecs.push_back(mk(1, 8'h00, 0, 0, 8'd0, 0, 1, 9'd3, 0, 1, 8'hFF));
`else
        vecs.push_back(mk(1, 8'h33, 1, 0, 8'd0, 0, 1, 9'd3, 0, 1, 8'hFF));
`endif
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'd1, 0, 1, 9'd3, 0, 1, 8'h22));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'd5, 0, 1, 9'd3, 0, 1, 8'hFF));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'd0, 0, 1, 9'd3, 0, 1, 8'h11));
        vecs.push_back(mk(1, 8'h77, 1, 0, 8'd2, 0, 1, 9'd3, 0, 1, 8'h33));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'd3, 0, 1, 9'd3, 0, 1, 8'hFF));
        vecs.push_back(mk(1, 8'h55, 1, 1, 8'd0, 1, 0, 9'd0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'd0, 1, 0, 9'd0, 0, 1, 8'hFF));
`ifdef BORUSS_IMEM_CHECKSUM_EN
        vecs.push_back(mk(1, 8'hAA, 1, 0, 8'd0, 1, 0, 9'd1, 0, 1, 8'hFF));
        vecs.push_back(mk(1, 8'hAA, 0, 0, 8'd0, 0, 1, 9'd1, 0, 1, 8'hFF));
`else
        vecs.push_back(mk(1, 8'hAA, 1, 0, 8'd0, 0, 1, 9'd1, 0, 1, 8'hFF));
`endif
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'd0, 0, 1, 9'd1, 0, 1, 8'hAA));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'd1, 0, 1, 9'd1, 0, 1, 8'h22));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'd2, 0, 1, 9'd1, 0, 1, 8'h33));

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst data", 32'(instruction_data), 32'hFF);
        check("rst ready", 32'(load_ready), 32'd0);
        check("rst run", 32'(cpu_run), 32'd0);
        check("rst count", 32'(load_count), 32'd0);
        check("rst error", 32'(load_error), 32'd0);
        reset = 1'b0;
        clear_phase("init");

        // ---------------- table application ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].restart, vecs[i].addr);
            tick();
            check($sformatf("vec%0d ready", i), 32'(load_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d run", i), 32'(cpu_run), 32'(vecs[i].exp_run));
            check($sformatf("vec%0d count", i), 32'(load_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d error", i), 32'(load_error), 32'(vecs[i].exp_error));
            if (vecs[i].chk_idata) begin
                check($sformatf("vec%0d idata", i), 32'(instruction_data), 32'(vecs[i].exp_idata));
            end
        end
        idle_drive();

        // ---------------- overflow: 257 bytes then last ----------------
        restart_pulse("ovf");
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
            tick();
            if (i == 255) begin
                check("ovf full count", 32'(load_count), 32'd256);
                check("ovf full error", 32'(load_error), 32'd0);
            end
        end
        check("ovf error", 32'(load_error), 32'd1);
        check("ovf count", 32'(load_count), 32'd256);
        check("ovf ready", 32'(load_ready), 32'd1);
        check("ovf run", 32'(cpu_run), 32'd0);
        drive(1'b1, 8'h5A, 1'b1, 1'b0, 8'h00);
        tick();
        idle_drive();
        check("ovf last run", 32'(cpu_run), 32'd0);
        check("ovf last ready", 32'(load_ready), 32'd1);
        check("ovf last count", 32'(load_count), 32'd0);
`ifdef BORUSS_IMEM_CHECKSUM_EN
        check("ovf last error", 32'(load_error), 32'd1);
`else
        check("ovf last error", 32'(load_error), 32'd0);
`endif
        tick();
        check("ovf idle run", 32'(cpu_run), 32'd0);
        load_one(8'h01);
        check("ovf reload run", 32'(cpu_run), 32'd1);
        check("ovf reload error", 32'(load_error), 32'd0);
        read_check("ovf rd200", 8'd200, 8'hC8);
        read_check("ovf rd1", 8'd1, 8'h01);
        read_check("ovf rd0", 8'd0, 8'h01);

        // ---------------- reset in the middle of LOAD ----------------
        restart_pulse("mid");
        drive(1'b1, 8'h12, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b1, 8'h34, 1'b0, 1'b0, 8'h00);
        tick();
        idle_drive();
        check("mid count", 32'(load_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("mid rst ready", 32'(load_ready), 32'd0);
        check("mid rst count", 32'(load_count), 32'd0);
        check("mid rst run", 32'(cpu_run), 32'd0);
        check("mid rst data", 32'(instruction_data), 32'hFF);
        tick();
        reset = 1'b0;
        clear_phase("mid");
        load_one(8'h77);
        check("mid reload run", 32'(cpu_run), 32'd1);
        read_check("mid rd1", 8'd1, 8'hFF);
        read_check("mid rd200", 8'd200, 8'hFF);
        read_check("mid rd0", 8'd0, 8'h77);

`ifdef BORUSS_IMEM_CHECKSUM_EN
        // ---------------- checksum match / mismatch ----------------
        restart_pulse("ck");
        drive(1'b1, 8'h0F, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b1, 8'hF0, 1'b1, 1'b0, 8'h00);
        tick();
        check("ck wait ready", 32'(load_ready), 32'd1);
        check("ck wait run", 32'(cpu_run), 32'd0);
        check("ck wait count", 32'(load_count), 32'd2);
        drive(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
        tick();
        check("ck ok run", 32'(cpu_run), 32'd1);
        check("ck ok count", 32'(load_count), 32'd2);
        read_check("ck rd1", 8'd1, 8'hF0);
        restart_pulse("ck2");
        drive(1'b1, 8'h0F, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b1, 8'hF0, 1'b1, 1'b0, 8'h00);
        tick();
        drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        tick();
        idle_drive();
        check("ck bad error", 32'(load_error), 32'd1);
        check("ck bad run", 32'(cpu_run), 32'd0);
        check("ck bad ready", 32'(load_ready), 32'd1);
        tick();
        check("ck bad hold", 32'(load_error), 32'd1);
        drive(1'b1, 8'h01, 1'b0, 1'b0, 8'h00);
        tick();
        idle_drive();
        check("ck clr error", 32'(load_error), 32'd0);
        check("ck clr count", 32'(load_count), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
